// File: rtl/myo_spi_responder.sv
// Oversampled SPI slave standing in for the myo motor board: takes one PWM
// reference per frame and returns a header plus a position/velocity/spring snapshot.

module myo_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else begin
      pipe[0] <= d;
      for (int s = 1; s < STAGES; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign q = pipe[STAGES-1];
endmodule

module myo_spi_responder #(
  parameter int          FRAME_WORDS = 5,
  parameter logic [15:0] HEADER      = 16'h8000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_sck_i,
  input  logic        spi_ssel_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe_o,
  input  logic [31:0] position_i,
  input  logic [15:0] velocity_i,
  input  logic [15:0] displacement_i,
  output logic [15:0] pwm_ref_o,
  output logic        pwm_valid_o,
  output logic        frame_done_o,
  output logic        frame_error_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] WC_GOOD = 3'(FRAME_WORDS);
  localparam logic [2:0] WC_SAT  = 3'(FRAME_WORDS + 1);

  // bit 2 = SCK, bit 1 = SS_N, bit 0 = MOSI
  logic [2:0] pin_s, pin_d;

  myo_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   ({spi_sck_i, spi_ssel_i, spi_mosi_i}),
    .q   (pin_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pin_d <= '0;
    else       pin_d <= pin_s;
  end

  logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_s;
  assign sck_rise = pin_s[2] & ~pin_d[2];
  assign sck_fall = ~pin_s[2] & pin_d[2];
  assign ss_rise  = pin_s[1] & ~pin_d[1];
  assign ss_fall  = ~pin_s[1] & pin_d[1];
  assign mosi_s   = pin_s[0];

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [2:0]  word_cnt;
  logic [15:0] tx_sh, rx_sh, pending;
  logic [15:0] tx_buf [1:4];
  logic [15:0] rx_next, next_word;

  assign rx_next = {rx_sh[14:0], mosi_s};

  // Words past the snapshot go out as zeros.
  always_comb begin
    next_word = 16'h0000;
    case (word_cnt + 3'd1)
      3'd1:    next_word = tx_buf[1];
      3'd2:    next_word = tx_buf[2];
      3'd3:    next_word = tx_buf[3];
      3'd4:    next_word = tx_buf[4];
      default: next_word = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      pending       <= '0;
      for (int i = 1; i <= 4; i++) tx_buf[i] <= '0;
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      pwm_ref_o     <= '0;
      pwm_valid_o   <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_error_o <= 1'b0;
    end else begin
      pwm_valid_o   <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_error_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_buf[1]     <= position_i[31:16];
            tx_buf[2]     <= position_i[15:0];
            tx_buf[3]     <= velocity_i;
            tx_buf[4]     <= displacement_i;
            tx_sh         <= HEADER;
            bit_cnt       <= '0;
            word_cnt      <= '0;
            spi_miso_oe_o <= 1'b1;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          // SS_N rise takes priority over any SCK edge seen in the same cycle.
          if (ss_rise) begin
            spi_miso_oe_o <= 1'b0;
            spi_miso_o    <= 1'b0;
            state         <= DONE;
          end else if (sck_rise) begin
            spi_miso_o <= tx_sh[15];
            tx_sh      <= {tx_sh[14:0], 1'b0};
          end else if (sck_fall) begin
            rx_sh   <= rx_next;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              if (word_cnt != WC_SAT) word_cnt <= word_cnt + 3'd1;
              tx_sh <= next_word;
              if (word_cnt == 3'd0) pending <= rx_next;
            end
          end
        end
        DONE: begin
          if (bit_cnt == 4'd0 && word_cnt == WC_GOOD) begin
            pwm_ref_o    <= pending;
            pwm_valid_o  <= 1'b1;
            frame_done_o <= 1'b1;
          end else begin
            frame_error_o <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_myo_spi_responder.sv
// Bench for myo_spi_responder: a bit-banged CPOL=0/CPHA=1 master drives frames,
// and the expected MISO words, pulses and PWM reference come from a frame-level model.

module tb_myo_spi_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0, ssel = 1'b1, mosi = 1'b0;
  logic        miso, miso_oe;
  logic [31:0] position = '0;
  logic [15:0] velocity = '0, displacement = '0;
  logic [15:0] pwm_ref;
  logic        pwm_valid, frame_done, frame_error;

  always #5 clk = ~clk;

  myo_spi_responder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .spi_sck_i      (sck),
    .spi_ssel_i     (ssel),
    .spi_mosi_i     (mosi),
    .spi_miso_o     (miso),
    .spi_miso_oe_o  (miso_oe),
    .position_i     (position),
    .velocity_i     (velocity),
    .displacement_i (displacement),
    .pwm_ref_o      (pwm_ref),
    .pwm_valid_o    (pwm_valid),
    .frame_done_o   (frame_done),
    .frame_error_o  (frame_error)
  );

  int          errs = 0, checks = 0;
  int          n_valid = 0, n_done = 0, n_err = 0;
  bit          in_reset = 1'b1;
  logic [15:0] prev_ref = '0;
  logic [15:0] model_ref = '0;
  logic [15:0] rxw   [0:7];
  logic [15:0] exp_w [0:7];
  int          chg_bit = -1, rst_bit = -1;
  logic [31:0] chg_pos = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle: valid and done coincide; the reference moves only with a valid pulse.
  always @(negedge clk) begin
    if (!in_reset) begin
      checks++;
      if (pwm_valid !== frame_done || (pwm_ref !== prev_ref && pwm_valid !== 1'b1)) begin
        errs++;
        $display("FAIL cycle_monitor: valid=%b done=%b ref=%h prev=%h", pwm_valid, frame_done, pwm_ref, prev_ref);
      end
      n_valid += int'(pwm_valid);
      n_done  += int'(frame_done);
      n_err   += int'(frame_error);
    end
    prev_ref = pwm_ref;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input int nbits, input logic [15:0] w0);
    logic [15:0] mw [0:7];
    mw[0] = w0;
    for (int i = 1; i < 8; i++) mw[i] = 16'($urandom);
    exp_w[0] = 16'h8000;
    exp_w[1] = position[31:16];
    exp_w[2] = position[15:0];
    exp_w[3] = velocity;
    exp_w[4] = displacement;
    for (int i = 5; i < 8; i++) exp_w[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rxw[i] = 16'h0000;
    ssel = 1'b0;
    cyc(10);
    chk("oe_in_frame", miso_oe, 1);
    for (int b = 0; b < nbits; b++) begin
      if (b == chg_bit) position = chg_pos;
      if (b == rst_bit) begin
        #2 rst = 1'b1; in_reset = 1'b1;
        #1;
        chk("async_rst_outputs", {pwm_ref, pwm_valid, frame_done, frame_error, miso, miso_oe}, 0);
        @(negedge clk) rst = 1'b0;
        cyc(2);
        in_reset = 1'b0;
        break;
      end
      sck  = 1'b1;
      mosi = mw[b/16][15 - b%16];
      cyc(5);
      sck = 1'b0;
      rxw[b/16][15 - b%16] = miso;
      cyc(5);
    end
    ssel = 1'b1;
    mosi = 1'b0;
    cyc(12);
  endtask

  task automatic check_frame(input int nbits, input logic [15:0] w0, input string name);
    int v0, d0, e0, full;
    bit good, rs;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    rs = (rst_bit >= 0 && rst_bit < nbits);
    run_frame(nbits, w0);
    full = rs ? rst_bit / 16 : nbits / 16;
    if (full > 8) full = 8;
    for (int i = 0; i < full; i++) chk($sformatf("%s_miso_w%0d", name, i), rxw[i], exp_w[i]);
    good = !rs && nbits == 80;
    if (rs) model_ref = 16'h0000;
    else if (good) model_ref = w0;
    chk({name, "_done_cnt"},  n_done - d0,  good);
    chk({name, "_valid_cnt"}, n_valid - v0, good);
    chk({name, "_err_cnt"},   n_err - e0,   !good && !rs);
    chk({name, "_pwm_ref"},   pwm_ref, model_ref);
    chk({name, "_oe_idle"},   {miso_oe, miso}, 0);
    chg_bit = -1;
    rst_bit = -1;
  endtask

  initial begin
    int lens [0:7];
    lens = '{80, 80, 80, 48, 64, 96, 112, 37};
    cyc(3);
    chk("reset_outputs", {pwm_ref, pwm_valid, frame_done, frame_error, miso, miso_oe}, 0);
    rst = 1'b0;
    cyc(6);
    in_reset = 1'b0;

    position = 32'h12345678; velocity = 16'hFFF6; displacement = 16'h0042;
    check_frame(80, 16'h01F4, "good");
    chk("good_w0_lit", rxw[0], 16'h8000);
    chk("good_w1_lit", rxw[1], 16'h1234);
    chk("good_w2_lit", rxw[2], 16'h5678);
    chk("good_w3_lit", rxw[3], 16'hFFF6);
    chk("good_w4_lit", rxw[4], 16'h0042);
    chk("good_ref_lit", pwm_ref, 16'h01F4);

    check_frame(48, 16'h0ABC, "short");
    chk("short_ref_lit", pwm_ref, 16'h01F4);
    check_frame(40, 16'h0DEF, "partial");
    check_frame(80, 16'h0100, "good2");
    chk("good2_ref_lit", pwm_ref, 16'h0100);

    chg_bit = 20; chg_pos = 32'hDEADBEEF;
    check_frame(80, 16'h0200, "snap_a");
    chk("snap_a_w1_lit", rxw[1], 16'h1234);
    chk("snap_a_w2_lit", rxw[2], 16'h5678);
    check_frame(80, 16'h0300, "snap_b");
    chk("snap_b_w1_lit", rxw[1], 16'hDEAD);
    chk("snap_b_w2_lit", rxw[2], 16'hBEEF);

    rst_bit = 40;
    check_frame(80, 16'h0400, "rst_mid");
    chk("rst_mid_ref_lit", pwm_ref, 16'h0000);
    check_frame(80, 16'h0500, "after_rst");
    chk("after_rst_ref_lit", pwm_ref, 16'h0500);

    check_frame(96, 16'h0600, "long");
    chk("long_w5_lit", rxw[5], 16'h0000);
    chk("long_ref_lit", pwm_ref, 16'h0500);

    for (int r = 0; r < 12; r++) begin
      int nb;
      position     = $urandom;
      velocity     = 16'($urandom);
      displacement = 16'($urandom);
      nb = (r == 11) ? int'($urandom_range(1, 100)) : lens[$urandom_range(0, 7)];
      check_frame(nb, 16'($urandom), $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/myo_spi_responder.md
Name: myo_spi_responder

Overview:
- SPI slave that models the motor-board end of the myo SPI link, so the FPGA-side master can be exercised in-system and on benches.
- Runs on the fabric clock and oversamples SCK, SS_N and MOSI.
- Per frame it receives one 16-bit PWM reference word and returns a snapshot of position, velocity and spring displacement, framed by a header word.
- Sits between GPIO pins or loopback and a plant-model register file.

Parameters:
- FRAME_WORDS, 5, number of 16-bit words per SS_N-low frame; fixed at 5, others unsupported.
- HEADER, 16'h8000, word 0 returned on MISO.
- SYNC_STAGES, 2, synchronizer depth for the SCK, SS_N and MOSI inputs.

Ports:
- clk_i  in  1  fabric clock; must be at least 8x the SCK frequency.
- rst_i  in  1  asynchronous active-high reset.
- spi_sck_i  in  1  SPI clock, CPOL=0 CPHA=1.
- spi_ssel_i  in  1  active-low slave select.
- spi_mosi_i  in  1  master data, MSB first.
- spi_miso_o  out  1  slave data, MSB first.
- spi_miso_oe_o  out  1  MISO output enable; high while selected.
- position_i  in  32  signed actual position, sampled at frame start.
- velocity_i  in  16  signed actual velocity, sampled at frame start.
- displacement_i  in  16  signed spring displacement, sampled at frame start.
- pwm_ref_o  out  16  last valid PWM reference received.
- pwm_valid_o  out  1  one-cycle pulse when pwm_ref_o updates.
- frame_done_o  out  1  one-cycle pulse at the end of a good frame.
- frame_error_o  out  1  one-cycle pulse at the end of a malformed frame.

Behaviour:
- Reset values: all outputs 0; spi_miso_o=0; state IDLE; counters 0; shift registers 0.
- Input path: SCK, SS_N and MOSI each pass through SYNC_STAGES flops, then one edge-detect flop. Pin-to-internal-event latency is 3 clk_i cycles.
- Frame timing:
  - Frame start: falling edge of synchronized SS_N.
  - Frame end: rising edge of synchronized SS_N.
  - SS_N held low at reset release does not start a frame; a falling edge is required.
- State IDLE:
  - On SS_N fall: snapshot the words {HEADER, position_i[31:16], position_i[15:0], velocity_i, displacement_i} into the TX buffer.
  - Load word 0 into the TX shifter; bit_cnt=0, word_cnt=0.
  - Assert spi_miso_oe_o; go to SHIFT.
- State SHIFT:
  - SCK rising: drive spi_miso_o with TX shifter bit 15, then shift left.
  - SCK falling: shift synchronized MOSI into RX shifter bit 0; bit_cnt+1.
  - When bit_cnt wraps 15->0:
    - word_cnt+1.
    - Load the next TX word; word index >= FRAME_WORDS loads 16'h0000.
    - If word_cnt was 0, latch the RX word into a pending register.
- SS_N rise from any state except IDLE: go to DONE for one cycle, then IDLE. spi_miso_oe_o and spi_miso_o drop to 0 on that cycle.
- DONE:
  - Good frame means bit_cnt==0 and word_cnt==FRAME_WORDS.
  - Good frame: pwm_ref_o <= pending, pwm_valid_o=1, frame_done_o=1.
  - Otherwise: frame_error_o=1 and pwm_ref_o is unchanged.
- Extra words beyond FRAME_WORDS: returned as zeros; word_cnt saturates at FRAME_WORDS+1, which makes the frame an error.
- Same-cycle SCK edge and SS_N rise: the SS_N rise wins and that SCK edge is ignored.
- Changes to position_i and the other sample inputs mid-frame do not affect the current frame.
- rst_i mid-frame: immediate return to IDLE with reset values; the remainder of that frame is ignored until the next SS_N fall.
- Arithmetic: counters are 4-bit (bit_cnt) and 3-bit (word_cnt); no signed arithmetic; data is passed through bit-exact.

Test Plan:
- Good frame: reset, position_i=32'h12345678, velocity_i=16'hFFF6, displacement_i=16'h0042; master sends 5 words {16'h01F4, 0, 0, 0, 0} at SCK=clk/10 -> MISO words 8000, 1234, 5678, FFF6, 0042; pwm_ref_o=16'h01F4; pwm_valid_o and frame_done_o each pulse once for 1 cycle.
- Short frame: SS_N rises after 3 words -> frame_error_o pulses; pwm_ref_o keeps its previous value 16'h01F4; no pwm_valid_o pulse.
- Partial word: SS_N rises after 40 bits -> frame_error_o=1 and no update; the next good frame with word 0 = 16'h0100 gives pwm_ref_o=16'h0100.
- Snapshot timing: change position_i to 32'hDEADBEEF after word 0 of a frame -> MISO still returns 1234/5678; the next frame returns DEAD/BEEF.
- Async reset: assert rst_i during word 2 -> all outputs 0 immediately with no clk_i edge needed; the next complete frame is received correctly.
- Long frame: 6 words -> word 5 on MISO is 0000; frame_error_o=1.
